// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the flood-risk back end: risk levels,
// default thresholds matching the inference centroids, and UART framing.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MED  = 2'd1,
        HIGH = 2'd2
    } risk_level_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int T_MED_DEF  = 85;
    localparam int T_HIGH_DEF = 170;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// load is accepted when ready is high; ready also covers the last stop cycle.
module uart_tx_8n1
    import fuzzy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          last_tick;

    assign last_tick = (clk_cnt == LAST_TICK);
    // Accepting during the final stop cycle makes back-to-back frames gapless.
    assign ready = (state == TX_IDLE) || (state == TX_STOP && last_tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            tx      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (load) begin
                        state   <= TX_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        shreg   <= data;
                        clk_cnt <= '0;
                    end
                end
                TX_START: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (last_tick) begin
                        clk_cnt <= '0;
                        if (load) begin
                            state <= TX_START;
                            tx    <= 1'b0;
                            shreg <= data;
                        end else begin
                            state <= TX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/risk_alert_tx.sv
// Risk classifier with hysteresis and persistence; each committed level change
// is sent as a UART 8N1 byte {level, risk[7:2]}. Optional RISK_ALERT_HEARTBEAT_EN.
module risk_alert_tx
    import fuzzy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int T_MED        = T_MED_DEF,
    parameter int T_HIGH       = T_HIGH_DEF,
    parameter int HYST         = 8,
    parameter int PERSIST      = 4,
    parameter int HEARTBEAT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] risk,
    input  logic       risk_valid,
    output logic [1:0] level,
    output logic       alarm,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_drop
);

    if (!(HYST < T_MED && T_MED < T_HIGH && T_HIGH <= 255 && PERSIST >= 1 &&
          PERSIST <= 15 && CLKS_PER_BIT >= 2 && HEARTBEAT >= 1)) begin : g_bad_params
        $error("risk_alert_tx: illegal parameter combination");
    end

    localparam logic [7:0] T_MED_UP  = 8'(T_MED);
    localparam logic [7:0] T_HIGH_UP = 8'(T_HIGH);
    localparam logic [7:0] T_MED_DN  = 8'(T_MED - HYST);
    localparam logic [7:0] T_HIGH_DN = 8'(T_HIGH - HYST);

    risk_level_t level_q, prev_cand, cand;
    logic [3:0]  persist_cnt, next_cnt;
    logic        commit, hb_fire, queue, tx_load, tx_ready;
    logic        pend_full;
    logic [7:0]  pend_byte, new_byte;

    always_comb begin
        cand = level_q;
        case (level_q)
            LOW: begin
                if (risk >= T_HIGH_UP)     cand = HIGH;
                else if (risk >= T_MED_UP) cand = MED;
            end
            MED: begin
                if (risk >= T_HIGH_UP)     cand = HIGH;
                else if (risk < T_MED_DN)  cand = LOW;
            end
            HIGH: begin
                if (risk < T_MED_DN)       cand = LOW;
                else if (risk < T_HIGH_DN) cand = MED;
            end
            default: cand = LOW;
        endcase
    end

    always_comb begin
        next_cnt = '0;
        if (cand != level_q)
            next_cnt = (cand == prev_cand) ? persist_cnt + 4'd1 : 4'd1;
    end

    assign commit = risk_valid && (cand != level_q) && (next_cnt >= 4'(PERSIST));

`ifdef RISK_ALERT_HEARTBEAT_EN
    logic [15:0] hb_cnt;

    assign hb_fire = risk_valid && !commit && (hb_cnt == 16'(HEARTBEAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hb_cnt <= '0;
        else if (risk_valid)
            hb_cnt <= (commit || hb_fire) ? 16'd0 : hb_cnt + 16'd1;
    end
`else
    assign hb_fire = 1'b0;
`endif

    assign queue    = commit || hb_fire;
    assign new_byte = commit ? {cand, risk[7:2]} : {level_q, risk[7:2]};
    assign tx_load  = pend_full && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= LOW;
            prev_cand   <= LOW;
            persist_cnt <= '0;
            alarm       <= 1'b0;
            pend_full   <= 1'b0;
            pend_byte   <= '0;
            frame_drop  <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            if (risk_valid) begin
                prev_cand <= cand;
                if (commit) begin
                    level_q     <= cand;
                    alarm       <= (cand == HIGH);
                    persist_cnt <= '0;
                end else begin
                    persist_cnt <= next_cnt;
                end
            end
            // A byte leaving for the transmitter on this edge is not a drop.
            if (queue) begin
                pend_byte  <= new_byte;
                pend_full  <= 1'b1;
                frame_drop <= pend_full && !tx_load;
            end else if (tx_load) begin
                pend_full <= 1'b0;
            end
        end
    end

    assign level = level_q;

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst_n(rst_n),
        .data (pend_byte),
        .load (tx_load),
        .ready(tx_ready),
        .busy (tx_busy),
        .tx   (tx)
    );

endmodule
